// File: rtl/bus_mig_resp_pkg.sv
// Shared types and constants for the bus_mig_resp line responder.
// Holds the FSM encoding, MIG command codes and line geometry.
package bus_mig_resp_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WGATHER,
    WISSUE,
    RISSUE,
    RWAIT,
    RSTREAM
  } bmr_state_e;

  localparam logic [2:0] MIG_CMD_WRITE = 3'd0;
  localparam logic [2:0] MIG_CMD_READ  = 3'd1;

  localparam int LINE_BYTES = 16;
  localparam int LINE_OFS_W = $clog2(LINE_BYTES);

  // Saturating increment for the optional statistics counters.
  function automatic logic [31:0] sat_inc(input logic [31:0] value);
    return (&value) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/bus_mig_resp_line_buf.sv
// One cache line held as BEATS slots of data plus a per-byte mask, with a
// single beat index shared by the write-gather and read-stream paths.
module bus_mig_resp_line_buf #(
  parameter int BEATS  = 4,
  parameter int BEAT_W = 32,
  localparam int IDX_W  = $clog2(BEATS),
  localparam int STRB_W = BEAT_W / 8,
  localparam int LINE_W = BEATS * BEAT_W
) (
  input  logic              clk_core,
  input  logic              reset_n,
  input  logic              idx_clr,
  input  logic              beat_wr,
  input  logic              beat_adv,
  input  logic [BEAT_W-1:0] beat_wdata,
  input  logic [STRB_W-1:0] beat_wmask,
  input  logic              line_ld,
  input  logic [LINE_W-1:0] line_ldata,
  output logic [IDX_W-1:0]  idx,
  output logic [BEAT_W-1:0] beat_rdata,
  output logic [LINE_W-1:0] line_data,
  output logic [LINE_W/8-1:0] line_mask
);

  logic [BEAT_W-1:0] data_q [BEATS];
  logic [STRB_W-1:0] mask_q [BEATS];

  // NOTE: sequential state uses <= so every flop samples pre-edge values;
  // blocking = here would make the result depend on statement order.
  // NOTE: the slot array is reset because the MIG payload must read as zero
  // out of reset; a larger buffer would normally be left unreset.
  always_ff @(posedge clk_core or negedge reset_n) begin
    if (!reset_n) begin
      idx <= '0;
      for (int i = 0; i < BEATS; i++) begin
        data_q[i] <= '0;
        mask_q[i] <= '0;
      end
    end else begin
      if (line_ld) begin
        for (int i = 0; i < BEATS; i++) begin
          data_q[i] <= line_ldata[i*BEAT_W +: BEAT_W];
          mask_q[i] <= '0;
        end
      end else if (beat_wr) begin
        data_q[idx] <= beat_wdata;
        mask_q[idx] <= beat_wmask;
      end

      if (idx_clr) begin
        idx <= '0;
      end else if (beat_wr || beat_adv) begin
        idx <= idx + 1'b1;
      end
    end
  end

  assign beat_rdata = data_q[idx];

  // NOTE: assign every always_comb output a default first so no path
  // leaves it unassigned, which would infer a latch.
  always_comb begin
    line_data = '0;
    line_mask = '0;
    for (int i = 0; i < BEATS; i++) begin
      line_data[i*BEAT_W +: BEAT_W] = data_q[i];
      line_mask[i*STRB_W +: STRB_W] = mask_q[i];
    end
  end

endmodule

// File: rtl/bus_mig_resp.sv
// Core-bus responder terminating line refills/writebacks on the MIG app port.
// Optional BUS_MIG_RESP_STATS_EN adds saturating stat_reads/stat_writes/stat_stall.
module bus_mig_resp
  import bus_mig_resp_pkg::*;
#(
  parameter int ADDR_W = 28,
  parameter int BEATS  = 4,
  parameter int BEAT_W = 32
) (
  input  logic              clk_core,
  input  logic              reset_n,
  input  logic              bus_cmd_valid,
  output logic              bus_cmd_ready,
  input  logic              bus_cmd_read,
  input  logic [31:0]       bus_cmd_addr,
  input  logic              bus_wvalid,
  output logic              bus_wready,
  input  logic [BEAT_W-1:0] bus_wdata,
  input  logic [3:0]        bus_wstrb,
  output logic              bus_rvalid,
  output logic [BEAT_W-1:0] bus_rdata,
  output logic              bus_rlast,
  output logic              bus_wdone,
  output logic [ADDR_W-1:0] app_addr,
  output logic [2:0]        app_cmd,
  output logic              app_en,
  input  logic              app_rdy,
  output logic [127:0]      app_wdf_data,
  output logic [15:0]       app_wdf_mask,
  output logic              app_wdf_wren,
  output logic              app_wdf_end,
  input  logic              app_wdf_rdy,
  input  logic [127:0]      app_rd_data,
  input  logic              app_rd_data_valid,
  input  logic              init_calib_complete
);

  localparam int IDX_W = $clog2(BEATS);

  bmr_state_e state_q, state_d;

  logic             cmd_done_q, wdf_done_q;
  logic             cmd_done_nx, wdf_done_nx;
  logic             cmd_fire, wbeat_fire, app_cmd_fire, wdf_fire;
  logic             idx_clr, beat_adv, line_ld, last_beat;
  logic [IDX_W-1:0] idx;
  logic [BEAT_W-1:0] beat_rdata;

  // Offset bits and address bits above the MIG range carry no meaning here.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus_cmd_addr[31:ADDR_W], bus_cmd_addr[LINE_OFS_W-1:0]};

  assign cmd_fire     = bus_cmd_valid && bus_cmd_ready;
  assign wbeat_fire   = bus_wvalid && bus_wready;
  assign app_cmd_fire = app_en && app_rdy;
  assign wdf_fire     = app_wdf_wren && app_wdf_rdy;
  assign cmd_done_nx  = cmd_done_q || app_cmd_fire;
  assign wdf_done_nx  = wdf_done_q || wdf_fire;
  assign last_beat    = (idx == IDX_W'(BEATS - 1));
  assign idx_clr      = cmd_fire || line_ld;

  bus_mig_resp_line_buf #(
    .BEATS  (BEATS),
    .BEAT_W (BEAT_W)
  ) u_line_buf (
    .clk_core   (clk_core),
    .reset_n    (reset_n),
    .idx_clr    (idx_clr),
    .beat_wr    (wbeat_fire),
    .beat_adv   (beat_adv),
    .beat_wdata (bus_wdata),
    .beat_wmask (~bus_wstrb),
    .line_ld    (line_ld),
    .line_ldata (app_rd_data),
    .idx        (idx),
    .beat_rdata (beat_rdata),
    .line_data  (app_wdf_data),
    .line_mask  (app_wdf_mask)
  );

  always_ff @(posedge clk_core or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cmd_fire) state_d = bus_cmd_read ? RISSUE : WGATHER;
      WGATHER: if (wbeat_fire && last_beat) state_d = WISSUE;
      WISSUE:  if (cmd_done_nx && wdf_done_nx) state_d = IDLE;
      RISSUE:  if (app_rdy) state_d = RWAIT;
      RWAIT:   if (app_rd_data_valid) state_d = RSTREAM;
      RSTREAM: if (last_beat) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake strobes are decoded from registered state, so an asynchronous
  // reset clears app_en and app_wdf_wren without waiting for a clock.
  always_comb begin
    bus_cmd_ready = 1'b0;
    bus_wready    = 1'b0;
    bus_rvalid    = 1'b0;
    bus_rlast     = 1'b0;
    app_en        = 1'b0;
    app_wdf_wren  = 1'b0;
    line_ld       = 1'b0;
    beat_adv      = 1'b0;
    case (state_q)
      IDLE:    bus_cmd_ready = reset_n && init_calib_complete;
      WGATHER: bus_wready = 1'b1;
      WISSUE: begin
        app_en       = !cmd_done_q;
        app_wdf_wren = !wdf_done_q;
      end
      RISSUE:  app_en = 1'b1;
      RWAIT:   line_ld = app_rd_data_valid;
      RSTREAM: begin
        bus_rvalid = 1'b1;
        bus_rlast  = last_beat;
        beat_adv   = 1'b1;
      end
      default: ;
    endcase
  end

  assign app_wdf_end = app_wdf_wren;
  assign bus_rdata   = beat_rdata;

  // Command and write-data acceptance complete independently; bus_wdone
  // fires the cycle after whichever of the two finishes last.
  always_ff @(posedge clk_core or negedge reset_n) begin
    if (!reset_n) begin
      app_addr   <= '0;
      app_cmd    <= MIG_CMD_WRITE;
      cmd_done_q <= 1'b0;
      wdf_done_q <= 1'b0;
      bus_wdone  <= 1'b0;
    end else begin
      bus_wdone <= (state_q == WISSUE) && cmd_done_nx && wdf_done_nx;
      if (cmd_fire) begin
        app_addr   <= {bus_cmd_addr[ADDR_W-1:LINE_OFS_W], {LINE_OFS_W{1'b0}}};
        app_cmd    <= bus_cmd_read ? MIG_CMD_READ : MIG_CMD_WRITE;
        cmd_done_q <= 1'b0;
        wdf_done_q <= 1'b0;
      end else if (state_q == WISSUE) begin
        cmd_done_q <= cmd_done_nx;
        wdf_done_q <= wdf_done_nx;
      end
    end
  end

`ifdef BUS_MIG_RESP_STATS_EN
  logic [31:0] stat_reads, stat_writes, stat_stall;

  always_ff @(posedge clk_core or negedge reset_n) begin
    if (!reset_n) begin
      stat_reads  <= '0;
      stat_writes <= '0;
      stat_stall  <= '0;
    end else begin
      if (cmd_fire && bus_cmd_read) stat_reads  <= sat_inc(stat_reads);
      if (bus_wdone)                stat_writes <= sat_inc(stat_writes);
      if (app_en && !app_rdy)       stat_stall  <= sat_inc(stat_stall);
    end
  end
`else
`endif

  // Read data arriving with no read outstanding is dropped.
  rd_valid_only_in_rwait: assert property (
    @(posedge clk_core) disable iff (!reset_n)
    app_rd_data_valid |-> (state_q == RWAIT)
  );

endmodule

// File: tb/tb_bus_mig_resp.sv
// Self-checking bench for bus_mig_resp: directed vector table, hand-written
// corner sequences and random traffic against a byte-level memory model.
module tb_bus_mig_resp;

  localparam int TMO = 40;

  logic         clk_core = 1'b0;
  logic         reset_n;
  logic         bus_cmd_valid, bus_cmd_ready, bus_cmd_read;
  logic [31:0]  bus_cmd_addr;
  logic         bus_wvalid, bus_wready;
  logic [31:0]  bus_wdata;
  logic [3:0]   bus_wstrb;
  logic         bus_rvalid, bus_rlast, bus_wdone;
  logic [31:0]  bus_rdata;
  logic [27:0]  app_addr;
  logic [2:0]   app_cmd;
  logic         app_en, app_rdy;
  logic [127:0] app_wdf_data;
  logic [15:0]  app_wdf_mask;
  logic         app_wdf_wren, app_wdf_end, app_wdf_rdy;
  logic [127:0] app_rd_data;
  logic         app_rd_data_valid, init_calib_complete;

  always #5 clk_core = ~clk_core;

  bus_mig_resp dut (
    .clk_core            (clk_core),
    .reset_n             (reset_n),
    .bus_cmd_valid       (bus_cmd_valid),
    .bus_cmd_ready       (bus_cmd_ready),
    .bus_cmd_read        (bus_cmd_read),
    .bus_cmd_addr        (bus_cmd_addr),
    .bus_wvalid          (bus_wvalid),
    .bus_wready          (bus_wready),
    .bus_wdata           (bus_wdata),
    .bus_wstrb           (bus_wstrb),
    .bus_rvalid          (bus_rvalid),
    .bus_rdata           (bus_rdata),
    .bus_rlast           (bus_rlast),
    .bus_wdone           (bus_wdone),
    .app_addr            (app_addr),
    .app_cmd             (app_cmd),
    .app_en              (app_en),
    .app_rdy             (app_rdy),
    .app_wdf_data        (app_wdf_data),
    .app_wdf_mask        (app_wdf_mask),
    .app_wdf_wren        (app_wdf_wren),
    .app_wdf_end         (app_wdf_end),
    .app_wdf_rdy         (app_wdf_rdy),
    .app_rd_data         (app_rd_data),
    .app_rd_data_valid   (app_rd_data_valid),
    .init_calib_complete (init_calib_complete)
  );

  typedef struct {
    bit           rd;
    logic [31:0]  addr;
    logic [127:0] data;      // write payload, or line returned by the MIG
    logic [15:0]  strb;
    int           dly_a;     // write: app_rdy delay; read: app_rdy delay
    int           dly_b;     // write: app_wdf_rdy delay; read: MIG latency
    logic [27:0]  exp_addr;
    logic [127:0] exp_data;  // write: app_wdf_data; read: beats 3..0
    logic [15:0]  exp_mask;
  } vec_t;

  vec_t         vecs [5];
  int           n_checks = 0;
  int           n_errors = 0;
  bit           drop_calib = 1'b0;
  logic [7:0]   ref_mem [256];
  logic [127:0] mig_mem [16];
  logic [27:0]  cap_addr;
  logic [127:0] cap_data;
  logic [15:0]  cap_mask;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus_cmd_valid = 0; bus_cmd_read = 0; bus_cmd_addr = '0;
    bus_wvalid = 0; bus_wdata = '0; bus_wstrb = '0;
    app_rdy = 0; app_wdf_rdy = 0; app_rd_data = '0; app_rd_data_valid = 0;
  endtask

  // Starts and ends on a falling edge; the accept happens on the rising edge between.
  task automatic send_cmd(input logic rd, input logic [31:0] addr);
    int n = 0;
    bus_cmd_valid = 1; bus_cmd_read = rd; bus_cmd_addr = addr;
    #1;
    while (bus_cmd_ready !== 1'b1 && n < TMO) begin
      @(negedge clk_core); #1; n++;
    end
    check("cmd_accept", bus_cmd_ready, 1'b1);
    @(negedge clk_core);
    bus_cmd_valid = 0;
    if (drop_calib) init_calib_complete = 0;
  endtask

  task automatic send_beats(input logic [127:0] wd, input logic [15:0] strb, input bit gaps);
    for (int i = 0; i < 4; i++) begin
      bus_wvalid = 0;
      if (gaps) repeat ($urandom_range(0, 1)) @(negedge clk_core);
      bus_wvalid = 1; bus_wdata = wd[32*i +: 32]; bus_wstrb = strb[4*i +: 4];
      check("wready", bus_wready, 1'b1);
      @(negedge clk_core);
    end
    bus_wvalid = 0;
  endtask

  task automatic write_issue(input int cmd_dly, input int wdf_dly, input bit chk,
                             input logic [27:0] ea, input logic [127:0] ed, input logic [15:0] em,
                             output logic [27:0] ca, output logic [127:0] cd, output logic [15:0] cm);
    bit cmd_seen = 0;
    bit wdf_seen = 0;
    int c = 0;
    ca = app_addr; cd = app_wdf_data; cm = app_wdf_mask;
    if (chk) begin
      check("wr_app_addr", app_addr, ea);
      check("wr_wdf_data", app_wdf_data, ed);
      check("wr_wdf_mask", app_wdf_mask, em);
    end
    check("wr_app_cmd", app_cmd, 3'd0);
    while (!(cmd_seen && wdf_seen) && c < TMO) begin
      check("app_en_hold", app_en, !cmd_seen);
      check("wdf_wren_hold", app_wdf_wren, !wdf_seen);
      check("wdf_end_hold", app_wdf_end, !wdf_seen);
      check("wdone_early", bus_wdone, 1'b0);
      app_rdy     = !cmd_seen && (c >= cmd_dly);
      app_wdf_rdy = !wdf_seen && (c >= wdf_dly);
      @(negedge clk_core);
      if (app_rdy) cmd_seen = 1;
      if (app_wdf_rdy) wdf_seen = 1;
      c++;
    end
    app_rdy = 0; app_wdf_rdy = 0;
    check("wdone_pulse", bus_wdone, 1'b1);
    check("wr_strobes_low", {app_en, app_wdf_wren}, 2'b00);
    @(negedge clk_core);
    check("wdone_once", bus_wdone, 1'b0);
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [127:0] wd, input logic [15:0] strb,
                          input int cmd_dly, input int wdf_dly, input bit chk, input bit gaps,
                          input logic [27:0] ea, input logic [127:0] ed, input logic [15:0] em,
                          output logic [27:0] ca, output logic [127:0] cd, output logic [15:0] cm);
    send_cmd(1'b0, addr);
    send_beats(wd, strb, gaps);
    write_issue(cmd_dly, wdf_dly, chk, ea, ed, em, ca, cd, cm);
  endtask

  // use_mig: the line comes from the MIG model at the address the DUT issued.
  task automatic do_read(input logic [31:0] addr, input int rdy_dly, input int lat,
                         input logic [127:0] line, input bit use_mig, input bit chk_addr,
                         input logic [27:0] ea, input logic [127:0] exp);
    logic [127:0] line_v = line;
    send_cmd(1'b1, addr);
    for (int c = 0; c <= rdy_dly; c++) begin
      check("rd_app_en", app_en, 1'b1);
      check("rd_app_cmd", app_cmd, 3'd1);
      if (chk_addr) check("rd_app_addr", app_addr, ea);
      app_rdy = (c == rdy_dly);
      if (app_rdy && use_mig) line_v = mig_mem[app_addr[7:4]];
      @(negedge clk_core);
    end
    app_rdy = 0;
    check("rd_en_drop", app_en, 1'b0);
    for (int l = 0; l < lat; l++) begin
      check("rvalid_early", bus_rvalid, 1'b0);
      @(negedge clk_core);
    end
    app_rd_data = line_v; app_rd_data_valid = 1;
    @(negedge clk_core);
    app_rd_data_valid = 0; app_rd_data = '0;
    for (int i = 0; i < 4; i++) begin
      check("rvalid", bus_rvalid, 1'b1);
      check("rdata", bus_rdata, exp[32*i +: 32]);
      check("rlast", bus_rlast, i == 3);
      @(negedge clk_core);
    end
    check("rvalid_end", bus_rvalid, 1'b0);
  endtask

  initial begin
    logic [31:0]  addr;
    logic [127:0] wd, exp;
    logic [15:0]  strb;
    int           base;

    vecs[0] = '{1'b0, 32'h0000_1234, 128'h44444444_33333333_22222222_11111111, 16'hFFFF, 0, 0,
                28'h0001230, 128'h44444444_33333333_22222222_11111111, 16'h0000};
    vecs[1] = '{1'b0, 32'h0000_200C, 128'h0D0D0D0D_0C0C0C0C_0B0B0B0B_0A0A0A0A, 16'hFF3F, 3, 0,
                28'h0002000, 128'h0D0D0D0D_0C0C0C0C_0B0B0B0B_0A0A0A0A, 16'h00C0};
    vecs[2] = '{1'b1, 32'h0000_0040, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, 16'h0000, 2, 1,
                28'h0000040, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, 16'h0000};
    vecs[3] = '{1'b0, 32'hF123_4567, 128'h89ABCDEF_01234567_FEDCBA98_76543210, 16'h0F01, 1, 2,
                28'h1234560, 128'h89ABCDEF_01234567_FEDCBA98_76543210, 16'hF0FE};
    vecs[4] = '{1'b1, 32'hABCD_EF9F, 128'h0F0E0D0C_0B0A0908_07060504_03020100, 16'h0000, 0, 0,
                28'hBCDEF90, 128'h0F0E0D0C_0B0A0908_07060504_03020100, 16'h0000};

    idle_inputs();
    init_calib_complete = 1;
    reset_n = 0;
    repeat (3) @(negedge clk_core);
    check("rst_cmd_ready", bus_cmd_ready, 1'b0);
    check("rst_valids", {bus_wready, bus_rvalid, bus_rlast, bus_wdone, app_en, app_wdf_wren}, 6'b0);
    check("rst_app_cmd_addr", {app_cmd, app_addr}, 31'h0);
    check("rst_wdf_payload", {app_wdf_mask, app_wdf_data}, 144'h0);
    reset_n = 1;
    @(negedge clk_core);

    // Calibration gating: no accept until init_calib_complete, then same-cycle accept.
    init_calib_complete = 0;
    bus_cmd_valid = 1; bus_cmd_read = 1; bus_cmd_addr = 32'h80;
    repeat (3) begin
      #1 check("calib_block", bus_cmd_ready, 1'b0);
      @(negedge clk_core);
    end
    init_calib_complete = 1;
    #1 check("calib_ready", bus_cmd_ready, 1'b1);
    do_read(32'h80, 0, 0, 128'h01234567_89ABCDEF_02468ACE_13579BDF, 0, 1, 28'h80,
            128'h01234567_89ABCDEF_02468ACE_13579BDF);

    foreach (vecs[k]) begin
      if (vecs[k].rd)
        do_read(vecs[k].addr, vecs[k].dly_a, vecs[k].dly_b, vecs[k].data, 0, 1,
                vecs[k].exp_addr, vecs[k].exp_data);
      else
        do_write(vecs[k].addr, vecs[k].data, vecs[k].strb, vecs[k].dly_a, vecs[k].dly_b, 1, 0,
                 vecs[k].exp_addr, vecs[k].exp_data, vecs[k].exp_mask, cap_addr, cap_data, cap_mask);
    end

    // Calibration dropping mid-read must not abort it, only block the next accept.
    drop_calib = 1;
    do_read(32'h500, 1, 2, 128'h5555_6666_7777_8888_9999_AAAA_BBBB_CCCC, 0, 1, 28'h500,
            128'h5555_6666_7777_8888_9999_AAAA_BBBB_CCCC);
    drop_calib = 0;
    #1 check("calib_drop_block", bus_cmd_ready, 1'b0);
    init_calib_complete = 1;
    @(negedge clk_core);

    // Asynchronous reset while the write is being issued.
    send_cmd(1'b0, 32'h300);
    send_beats(128'hA5A5A5A5_5A5A5A5A_C3C3C3C3_3C3C3C3C, 16'hFFFF, 0);
    check("rst_pre_strobes", {app_en, app_wdf_wren}, 2'b11);
    #1 reset_n = 0;
    #1;
    check("rst_strobes_drop", {app_en, app_wdf_wren}, 2'b00);
    check("rst_mid_ready", bus_cmd_ready, 1'b0);
    check("rst_mid_addr", app_addr, 28'h0);
    @(negedge clk_core);
    reset_n = 1;
    @(negedge clk_core);
    do_read(32'h310, 1, 2, 128'hCAFEF00D_DEADBEEF_0BADC0DE_FEEDFACE, 0, 1, 28'h310,
            128'hCAFEF00D_DEADBEEF_0BADC0DE_FEEDFACE);

    // Random traffic: byte-addressed reference memory versus the DUT plus a MIG memory.
    foreach (ref_mem[j]) ref_mem[j] = 8'h00;
    foreach (mig_mem[j]) mig_mem[j] = '0;
    for (int t = 0; t < 40; t++) begin
      addr = $urandom;
      base = int'({addr[7:4], 4'b0000});
      if ($urandom_range(0, 1) == 1) begin
        wd   = {$urandom, $urandom, $urandom, $urandom};
        strb = 16'($urandom);
        do_write(addr, wd, strb, $urandom_range(0, 3), $urandom_range(0, 3), 0, 1,
                 '0, '0, '0, cap_addr, cap_data, cap_mask);
        for (int i = 0; i < 4; i++)
          for (int b = 0; b < 4; b++)
            if (strb[4*i + b]) ref_mem[base + 4*i + b] = wd[32*i + 8*b +: 8];
        for (int b = 0; b < 16; b++)
          if (!cap_mask[b]) mig_mem[cap_addr[7:4]][8*b +: 8] = cap_data[8*b +: 8];
      end else begin
        for (int i = 0; i < 4; i++)
          for (int b = 0; b < 4; b++)
            exp[32*i + 8*b +: 8] = ref_mem[base + 4*i + b];
        do_read(addr, $urandom_range(0, 3), $urandom_range(0, 3), '0, 1, 0, '0, exp);
      end
    end

`ifdef BUS_MIG_RESP_STATS_EN
    reset_n = 0;
    @(negedge clk_core);
    reset_n = 1;
    @(negedge clk_core);
    do_read(32'h10, 5, 0, 128'h1, 0, 0, '0, 128'h1);
    do_read(32'h20, 0, 0, 128'h2, 0, 0, '0, 128'h2);
    do_write(32'h30, 128'h3, 16'hFFFF, 0, 0, 0, 0, '0, '0, '0, cap_addr, cap_data, cap_mask);
    check("stat_reads", dut.stat_reads, 32'd2);
    check("stat_writes", dut.stat_writes, 32'd1);
    check("stat_stall", dut.stat_stall, 32'd5);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
